// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands DIGIT bits per clock,
// least significant slice first. One operation is in flight at a time.
// The result (sum, carry out, signed overflow) is held until the consumer
// takes it.
// Optional feature macro: DSA_SUB_EN. When defined, it adds the 'sub' port,
// and sub=1 computes x - y as x + ~y + 1.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef DSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [31:0]      base;
  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;

  // Two's-complement overflow: both operands share a sign that the result lacks.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Accepting is only possible from IDLE, and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;

  // Operand B and the initial carry for the selected operation.
  always_comb begin
`ifdef DSA_SUB_EN
    b_in = sub ? ~y : y;
    c_in = sub ? 1'b1 : cin;
`else
    b_in = y;
    c_in = cin;
`endif
  end

  // Slice adder: current slice of A and B, plus the carry from the previous slice.
  always_comb begin
    base      = 32'(cnt) * 32'(DIGIT);
    slice_sum = {1'b0, a_q[base +: DIGIT]} + {1'b0, b_q[base +: DIGIT]}
              + {{DIGIT{1'b0}}, carry_q};
    acc_next  = acc_q;
    acc_next[base +: DIGIT] = slice_sum[DIGIT-1:0];
  end

  // Control FSM. Partial sums build up in acc_q, and the visible result
  // registers change only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= x;
            b_q     <= b_in;
            carry_q <= c_in;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        // RUN: one slice per edge, LSB first
        RUN: begin
          acc_q   <= acc_next;
          carry_q <= slice_sum[DIGIT];
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= acc_next;
            cout      <= slice_sum[DIGIT];
            ovf       <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], slice_sum[DIGIT-1]);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // DONE: hold the result until the consumer takes it
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed testbench for digit_serial_adder. It uses an 8-bit/2-bit-digit
// instance and a 32-bit single-digit instance. The subtraction tests are
// included when DSA_SUB_EN is defined.
module tb_digit_serial_adder;

  logic        clk;
  logic        rst;

  logic        iv8, ir8, ov8, or8, cin8, cout8, ovf8;
  logic [7:0]  x8, y8, sum8;
`ifdef DSA_SUB_EN
  logic        sub8;
`endif

  logic        iv32, ir32, ov32, or32, cin32, cout32, ovf32;
  logic [31:0] x32, y32, sum32;
`ifdef DSA_SUB_EN
  logic        sub32;
`endif

  int checks = 0;
  int errors = 0;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .cin(cin8),
`ifdef DSA_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  digit_serial_adder #(.WIDTH(32), .DIGIT(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .x(x32), .y(y32), .cin(cin32),
`ifdef DSA_SUB_EN
    .sub(sub32),
`endif
    .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one operation to the 8-bit instance, then waits for out_valid.
  // lat = edges counted from the accept edge, or -1 if out_valid never rose.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, output int lat);
    @(negedge clk);
    x8 = a; y8 = b; cin8 = c; iv8 = 1'b1;
`ifdef DSA_SUB_EN
    sub8 = s;
`endif
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ov8) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release8();
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", ir8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov8); end
    checks++; if ({sum8, cout8, ovf8} !== 10'h000) begin errors++; $display("FAIL reset_result got %h/%b/%b want 00/0/0", sum8, cout8, ovf8); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", ir8); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready32 got %b want 1", ir32); end
  endtask

  task automatic test_add_overflow();
    int lat;
    run8(8'h6B, 8'h5D, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_ovf_latency got %0d want 4", lat); end
    checks++; if (sum8 !== 8'hC8) begin errors++; $display("FAIL add_ovf_sum got %h want c8", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL add_ovf_cout got %b want 0", cout8); end
    checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL add_ovf_ovf got %b want 1", ovf8); end
    release8();
  endtask

  task automatic test_add_vectors();
    int lat;
    run8(8'h80, 8'h21, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add1_latency got %0d want 4", lat); end
    checks++; if ({sum8, cout8, ovf8} !== {8'hA1, 1'b0, 1'b0}) begin errors++; $display("FAIL add1_result got %h/%b/%b want a1/0/0", sum8, cout8, ovf8); end
    release8();
    run8(8'h40, 8'h11, 1'b1, 1'b0, lat);
    checks++; if ({sum8, cout8, ovf8} !== {8'h52, 1'b0, 1'b0}) begin errors++; $display("FAIL add_cin_result got %h/%b/%b want 52/0/0", sum8, cout8, ovf8); end
    release8();
    run8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    checks++; if ({sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL add_carry_result got %h/%b/%b want 00/1/0", sum8, cout8, ovf8); end
    release8();
`ifndef DSA_SUB_EN
    run8(8'h7F, 8'h00, 1'b1, 1'b0, lat);
    checks++; if ({sum8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin errors++; $display("FAIL add_cin_ovf_result got %h/%b/%b want 80/0/1", sum8, cout8, ovf8); end
    release8();
`endif
  endtask

`ifdef DSA_SUB_EN
  task automatic test_sub();
    int lat;
    run8(8'h10, 8'h20, 1'b0, 1'b1, lat);
    checks++; if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin errors++; $display("FAIL sub1_result got %h/%b/%b want f0/0/0", sum8, cout8, ovf8); end
    release8();
    run8(8'h80, 8'h01, 1'b1, 1'b1, lat);
    checks++; if ({sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin errors++; $display("FAIL sub2_result got %h/%b/%b want 7f/1/1", sum8, cout8, ovf8); end
    release8();
  endtask
`endif

  task automatic test_backpressure();
    int lat;
    run8(8'h12, 8'h34, 1'b0, 1'b0, lat);
    checks++; if ({sum8, cout8, ovf8} !== {8'h46, 1'b0, 1'b0}) begin errors++; $display("FAIL bp_result got %h/%b/%b want 46/0/0", sum8, cout8, ovf8); end
    @(negedge clk);
    iv8 = 1'b1; x8 = 8'hFF; y8 = 8'hFF; cin8 = 1'b1; or8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({ov8, ir8, sum8, cout8, ovf8} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%b %h/%b/%b want v=1 r=0 46/0/0", i, ov8, ir8, sum8, cout8, ovf8);
      end
    end
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    checks++; if ({ov8, ir8} !== 2'b01) begin errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", ov8, ir8); end
    @(posedge clk);
    #1;
    checks++; if ({ir8, sum8} !== {1'b1, 8'h46}) begin errors++; $display("FAIL bp_idle_hold got r=%b sum=%h want r=1 sum=46", ir8, sum8); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    x8 = 8'h6B; y8 = 8'h5D; cin8 = 1'b0; iv8 = 1'b1;
`ifdef DSA_SUB_EN
    sub8 = 1'b0;
`endif
    @(posedge clk);
    #1 iv8 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({ov8, sum8, cout8, ovf8} !== 11'h000) begin errors++; $display("FAIL rstmid_clear got v=%b %h/%b/%b want v=0 00/0/0", ov8, sum8, cout8, ovf8); end
    checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", ir8); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL rstmid_release got %b want 1", ir8); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL rstmid_no_result got v=%b want 0", ov8); end
    end
    run8(8'h01, 8'h01, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_new_latency got %0d want 4", lat); end
    checks++; if ({sum8, cout8, ovf8} !== {8'h02, 1'b0, 1'b0}) begin errors++; $display("FAIL rstmid_new_result got %h/%b/%b want 02/0/0", sum8, cout8, ovf8); end
    release8();
  endtask

  task automatic test_single_digit();
    int lat;
    @(negedge clk);
    x32 = 32'hFFFFFFFF; y32 = 32'h00000001; cin32 = 1'b0; iv32 = 1'b1;
`ifdef DSA_SUB_EN
    sub32 = 1'b0;
`endif
    @(posedge clk);
    #1 iv32 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (ov32) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL n1_latency got %0d want 1", lat); end
    checks++; if ({sum32, cout32, ovf32} !== {32'h00000000, 1'b1, 1'b0}) begin errors++; $display("FAIL n1_result got %h/%b/%b want 00000000/1/0", sum32, cout32, ovf32); end
    @(negedge clk) or32 = 1'b1;
    @(posedge clk);
    #1 or32 = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({ir32, ov32} !== 2'b10) begin errors++; $display("FAIL n1_return got r=%b v=%b want r=1 v=0", ir32, ov32); end
  endtask

  initial begin
    rst = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0;
    iv32 = 1'b0; or32 = 1'b0; x32 = '0; y32 = '0; cin32 = 1'b0;
`ifdef DSA_SUB_EN
    sub8 = 1'b0; sub32 = 1'b0;
`endif
    test_reset();
    test_add_overflow();
    test_add_vectors();
`ifdef DSA_SUB_EN
    test_sub();
`endif
    test_backpressure();
    test_reset_mid();
    test_single_digit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
